// File: rtl/seg_scan_driver_if.sv
// rtl/seg_scan_driver_if.sv - hex word handoff from the scroll logic into seg_scan_driver
interface seg_scan_driver_if;
  logic [15:0] disp_data;
  logic        disp_valid;
  logic        pending;

  modport master (
    output disp_data,
    output disp_valid,
    input  pending
  );

  modport slave (
    input  disp_data,
    input  disp_valid,
    output pending
  );
endinterface

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - four-digit multiplexed 7-seg driver with frame-aligned double buffer
// Optional decimal-point drive is enabled by defining SEG_DP_EN.
module seg_scan_driver #(
  parameter int DIV   = 131072,
  parameter int BLANK = 1024
) (
  input  logic                clk,
  input  logic                clr_n,
  seg_scan_driver_if.slave    bus,
  input  logic [3:0]          digit_en,
  input  logic [3:0]          dp_in,
  output logic                frame_done,
  output logic [3:0]          an,
  output logic [6:0]          seg,
  output logic                dp
);

  localparam int CW = $clog2(DIV);
  localparam int LW = CW + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  // One extra bit so BLANK=0 (lit for the whole slot) still compares correctly.
  localparam logic [LW-1:0] LIT_END  = LW'(DIV - BLANK);

  logic [CW-1:0] cnt;
  logic [1:0]    dig;
  logic [15:0]   active;
  logic [15:0]   shadow;
  logic          pending_q;
  logic          slot_end;
  logic          boundary;

  logic [3:0]    nib;
  logic          lit;
  logic [3:0]    an_next;
  logic [6:0]    seg_next;

  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    case (n)
      4'h0: hex_glyph = 7'h40;
      4'h1: hex_glyph = 7'h79;
      4'h2: hex_glyph = 7'h24;
      4'h3: hex_glyph = 7'h30;
      4'h4: hex_glyph = 7'h19;
      4'h5: hex_glyph = 7'h12;
      4'h6: hex_glyph = 7'h02;
      4'h7: hex_glyph = 7'h78;
      4'h8: hex_glyph = 7'h00;
      4'h9: hex_glyph = 7'h10;
      4'hA: hex_glyph = 7'h08;
      4'hB: hex_glyph = 7'h03;
      4'hC: hex_glyph = 7'h46;
      4'hD: hex_glyph = 7'h21;
      4'hE: hex_glyph = 7'h06;
      default: hex_glyph = 7'h0E;
    endcase
  endfunction

  assign slot_end = (cnt == CNT_LAST);
  assign boundary = slot_end && (dig == 2'd3);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt <= '0;
      dig <= 2'd0;
    end else if (slot_end) begin
      cnt <= '0;
      dig <= dig + 2'd1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // A strobe landing on the boundary goes straight to active so it is never
  // held back a whole frame.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      active    <= 16'h0000;
      shadow    <= 16'h0000;
      pending_q <= 1'b0;
    end else if (boundary) begin
      if (bus.disp_valid) begin
        active <= bus.disp_data;
        shadow <= bus.disp_data;
      end else if (pending_q) begin
        active <= shadow;
      end
      pending_q <= 1'b0;
    end else if (bus.disp_valid) begin
      shadow    <= bus.disp_data;
      pending_q <= 1'b1;
    end
  end

  assign bus.pending = pending_q;

  always_comb begin
    nib      = active[{dig, 2'b00} +: 4];
    lit      = digit_en[dig] && ({1'b0, cnt} < LIT_END);
    an_next  = 4'hF;
    if (lit) begin
      an_next = ~(4'b0001 << dig);
    end
    seg_next = hex_glyph(nib);
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      an         <= 4'hF;
      seg        <= 7'h7F;
      frame_done <= 1'b0;
    end else begin
      an         <= an_next;
      seg        <= seg_next;
      frame_done <= boundary;
    end
  end

`ifdef SEG_DP_EN
  logic dp_q;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      dp_q <= 1'b1;
    end else begin
      dp_q <= ~(lit & dp_in[dig]);
    end
  end

  assign dp = dp_q;
`else
  logic unused_dp_in;

  assign unused_dp_in = ^dp_in;
  assign dp           = 1'b1;
`endif

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - directed checks of seg_scan_driver with DIV=8, BLANK=2
module tb_seg_scan_driver;

  logic       clk;
  logic       clr_n;
  logic [3:0] digit_en;
  logic [3:0] dp_in;
  logic       frame_done;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int n_checks;
  int n_errors;

  seg_scan_driver_if bus ();

  seg_scan_driver #(.DIV(8), .BLANK(2)) dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .bus        (bus),
    .digit_en   (digit_en),
    .dp_in      (dp_in),
    .frame_done (frame_done),
    .an         (an),
    .seg        (seg),
    .dp         (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] tbl [16];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return tbl[n];
  endfunction

  task automatic wait_frame_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) seen = 1'b1;
    end
    if (!seen) chk("frame_done_timeout", 32'd0, 32'd1);
  endtask

  // Samples 32 cycles of one displayed frame, starting at slot 0 cycle 0.
  // Optional strobes are driven right after the sample with index sX_at.
  task automatic check_frame(input string tag, input logic [15:0] word, input logic [3:0] en,
                             input int s1_at, input logic [15:0] s1_d,
                             input int s2_at, input logic [15:0] s2_d);
    int         slot;
    int         c;
    logic       lit;
    logic [3:0] exp_an;
    logic       exp_dp;
    logic       exp_pend;
    logic [3:0] nib;
    for (int j = 0; j < 32; j++) begin
      @(negedge clk);
      slot     = j / 8;
      c        = j % 8;
      lit      = en[slot] && (c < 6);
      exp_an   = lit ? ~(4'b0001 << slot) : 4'hF;
      nib      = word[slot*4 +: 4];
`ifdef SEG_DP_EN
      exp_dp   = ~(lit & dp_in[slot]);
`else
      exp_dp   = 1'b1;
`endif
      exp_pend = (s1_at >= 0) && (s1_at < 30) && (j > s1_at) && (j < 31);
      chk({tag, "_an"}, 32'(an), 32'(exp_an));
      chk({tag, "_seg"}, 32'(seg), 32'(glyph(nib)));
      chk({tag, "_dp"}, 32'(dp), 32'(exp_dp));
      chk({tag, "_frame_done"}, 32'(frame_done), 32'(j == 31));
      chk({tag, "_pending"}, 32'(bus.pending), 32'(exp_pend));
      bus.disp_valid = 1'b0;
      if (j == s1_at) begin
        bus.disp_data  = s1_d;
        bus.disp_valid = 1'b1;
      end
      if (j == s2_at) begin
        bus.disp_data  = s2_d;
        bus.disp_valid = 1'b1;
      end
    end
    bus.disp_valid = 1'b0;
  endtask

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    clr_n          = 1'b0;
    bus.disp_data  = 16'h0000;
    bus.disp_valid = 1'b0;
    digit_en       = 4'hF;
    dp_in          = 4'b0010;

    repeat (3) @(negedge clk);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp", 32'(dp), 32'h1);
    chk("rst_pending", 32'(bus.pending), 32'h0);
    chk("rst_frame_done", 32'(frame_done), 32'h0);

    clr_n = 1'b1;
    #1 chk("rel_first_an", 32'(an), 32'hF);
    @(negedge clk);
    chk("rel_second_an", 32'(an), 32'hE);
    chk("rel_second_seg", 32'(seg), 32'h40);

    repeat (4) @(negedge clk);
    bus.disp_data  = 16'h1234;
    bus.disp_valid = 1'b1;
    @(negedge clk);
    chk("pre_rst_pending", 32'(bus.pending), 32'h1);
    #2 clr_n = 1'b0;
    #1;
    chk("mid_rst_an", 32'(an), 32'hF);
    chk("mid_rst_seg", 32'(seg), 32'h7F);
    chk("mid_rst_dp", 32'(dp), 32'h1);
    chk("mid_rst_pending", 32'(bus.pending), 32'h0);
    chk("mid_rst_frame_done", 32'(frame_done), 32'h0);
    repeat (2) @(negedge clk);
    chk("held_rst_pending", 32'(bus.pending), 32'h0);
    bus.disp_valid = 1'b0;
    clr_n          = 1'b1;
    #1 chk("rel2_first_an", 32'(an), 32'hF);
    @(negedge clk);
    chk("rel2_second_an", 32'(an), 32'hE);
    chk("rel2_second_seg", 32'(seg), 32'h40);

    bus.disp_data  = 16'h1234;
    bus.disp_valid = 1'b1;
    @(negedge clk);
    bus.disp_valid = 1'b0;
    chk("scan_pending", 32'(bus.pending), 32'h1);
    chk("scan_old_seg", 32'(seg), 32'h40);
    wait_frame_done();

    check_frame("scan", 16'h1234, 4'hF, -1, 16'h0000, -1, 16'h0000);
    check_frame("hold", 16'h1234, 4'hF, 12, 16'hABCD, -1, 16'h0000);
    check_frame("commit", 16'hABCD, 4'hF, 30, 16'h00FF, -1, 16'h0000);
    digit_en = 4'b0101;
    check_frame("bypass", 16'h00FF, 4'b0101, 5, 16'h1111, 20, 16'h2222);
    check_frame("last", 16'h2222, 4'b0101, -1, 16'h0000, -1, 16'h0000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
